// File: rtl/ae_pkg.sv
// Shared types and helpers for the auto-exposure statistics block.
package ae_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DIV  = 2'd1,
        ST_DONE = 2'd2
    } ae_state_e;

    // Sum width: enough headroom to add 2^cnt_w pixels of data_w bits.
    function automatic int sum_width(input int data_w, input int cnt_w);
        return data_w + cnt_w;
    endfunction

    // Increment amount for a saturating counter: 1 unless already all-ones.
    function automatic logic sat_inc_en(input logic at_max);
        return ~at_max;
    endfunction

endpackage

// File: rtl/ae_div.sv
// Sequential restoring divider, one quotient bit per cycle, MSB first.
// Latency is fixed at C_SUM_WIDTH cycles after start. `quotient` is the
// full result only in the cycle `done` is high (it carries the last bit
// combinationally so the caller can register it on that same edge).
module ae_div import ae_pkg::*; #(
    parameter int C_SUM_WIDTH = 32,
    parameter int C_CNT_WIDTH = 24
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   abort,
    input  logic [C_SUM_WIDTH-1:0] dividend,
    input  logic [C_CNT_WIDTH-1:0] divisor,
    output logic [C_SUM_WIDTH-1:0] quotient,
    output logic                   done
);
    localparam int STEP_W = $clog2(C_SUM_WIDTH + 1);
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(C_SUM_WIDTH - 1);

    logic [C_SUM_WIDTH-1:0] dvd_q, dvd_d, quo_q, quo_d, quo_step;
    logic [C_CNT_WIDTH-1:0] dvs_q, dvs_d;
    logic [C_CNT_WIDTH:0]   rem_q, rem_d, trial, rem_step;
    logic [STEP_W-1:0]      step_q, step_d;
    logic                   run_q, run_d, qbit;
    logic                   unused_rem_msb;

    // Remainder stays below the divisor, so its top bit is always zero.
    assign unused_rem_msb = rem_q[C_CNT_WIDTH];

    // One restoring step; a zero divisor forces every quotient bit to 0.
    always_comb begin
        trial    = {rem_q[C_CNT_WIDTH-1:0], dvd_q[C_SUM_WIDTH-1]};
        qbit     = (dvs_q != '0) && (trial >= {1'b0, dvs_q});
        rem_step = qbit ? (trial - {1'b0, dvs_q}) : trial;
        quo_step = {quo_q[C_SUM_WIDTH-2:0], qbit};
        done     = run_q && (step_q == LAST_STEP);
        quotient = quo_step;
        dvd_d    = dvd_q;
        dvs_d    = dvs_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        step_d   = step_q;
        run_d    = run_q;
        if (start) begin
            dvd_d  = dividend;
            dvs_d  = divisor;
            rem_d  = '0;
            quo_d  = '0;
            step_d = '0;
            run_d  = 1'b1;
        end else if (abort) begin
            run_d = 1'b0;
        end else if (run_q) begin
            dvd_d  = {dvd_q[C_SUM_WIDTH-2:0], 1'b0};
            rem_d  = rem_step;
            quo_d  = quo_step;
            step_d = step_q + 1'b1;
            if (done) run_d = 1'b0;
        end
    end

    // Divider state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            dvd_q  <= '0;
            dvs_q  <= '0;
            rem_q  <= '0;
            quo_q  <= '0;
            step_q <= '0;
            run_q  <= 1'b0;
        end else begin
            dvd_q  <= dvd_d;
            dvs_q  <= dvs_d;
            rem_q  <= rem_d;
            quo_q  <= quo_d;
            step_q <= step_d;
            run_q  <= run_d;
        end
    end

endmodule

// File: rtl/ae_stat.sv
// Auto-exposure statistics: per-frame window luminance sum and under/over
// counts, divided into a mean at each frame start and presented with a
// one-cycle stat_valid pulse.
module ae_stat import ae_pkg::*; #(
    parameter int C_DATA_WIDTH = 8,
    parameter int C_CNT_WIDTH  = 24,
    parameter int C_POS_WIDTH  = 12
) (
    input  logic                    pix_clk,
    input  logic                    reset,
    input  logic                    vs_in,
    input  logic                    hs_in,
    input  logic                    de_in,
    input  logic [C_DATA_WIDTH-1:0] data_in,
    input  logic [C_POS_WIDTH-1:0]  win_x0,
    input  logic [C_POS_WIDTH-1:0]  win_x1,
    input  logic [C_POS_WIDTH-1:0]  win_y0,
    input  logic [C_POS_WIDTH-1:0]  win_y1,
    input  logic [C_DATA_WIDTH-1:0] thr_lo,
    input  logic [C_DATA_WIDTH-1:0] thr_hi,
    output logic [C_DATA_WIDTH-1:0] mean_out,
    output logic [C_CNT_WIDTH-1:0]  pix_cnt,
    output logic [C_CNT_WIDTH-1:0]  under_cnt,
    output logic [C_CNT_WIDTH-1:0]  over_cnt,
    output logic                    stat_valid,
    output logic                    busy
);
    localparam int C_SUM_WIDTH = sum_width(C_DATA_WIDTH, C_CNT_WIDTH);

    logic                    vs_dly_q, vs_dly_d, de_dly_q, de_dly_d;
    logic [C_POS_WIDTH-1:0]  x_q, x_d, y_q, y_d;
    logic [C_POS_WIDTH-1:0]  wx0_q, wx0_d, wx1_q, wx1_d, wy0_q, wy0_d, wy1_q, wy1_d;
    logic [C_DATA_WIDTH-1:0] lo_q, lo_d, hi_q, hi_d;
    logic [C_SUM_WIDTH-1:0]  sum_q, sum_d;
    logic [C_SUM_WIDTH:0]    sum_ext;
    logic [C_CNT_WIDTH-1:0]  pix_q, pix_d, und_q, und_d, ovr_q, ovr_d;
    logic [C_CNT_WIDTH-1:0]  spix_q, spix_d, sund_q, sund_d, sovr_q, sovr_d;
    logic                    vs_ps, de_v, de_fall, in_win;
    logic                    div_start, div_abort, div_done;
    logic [C_SUM_WIDTH-1:0]  div_quo;
    logic [C_DATA_WIDTH-1:0] mean_clamped;
    ae_state_e               state_q;
    logic                    armed_q, stat_valid_q;
    logic [C_DATA_WIDTH-1:0] mean_q;
    logic [C_CNT_WIDTH-1:0]  pix_out_q, und_out_q, ovr_out_q;
    logic                    unused_hs;

    assign unused_hs = hs_in;

    // Edge detect, position counters, window compare and accumulators.
    always_comb begin
        vs_ps   = vs_in & ~vs_dly_q;
        de_v    = de_in & ~vs_in;
        de_fall = de_dly_q & ~de_v;
        in_win  = de_v && (x_q >= wx0_q) && (x_q <= wx1_q)
                       && (y_q >= wy0_q) && (y_q <= wy1_q);
        sum_ext = {1'b0, sum_q} + (C_SUM_WIDTH+1)'(data_in);
        vs_dly_d = vs_in;
        de_dly_d = de_v;
        x_d = de_v ? x_q + C_POS_WIDTH'(sat_inc_en(&x_q)) : '0;
        y_d = y_q;
        if (vs_ps)        y_d = '0;
        else if (de_fall) y_d = y_q + C_POS_WIDTH'(sat_inc_en(&y_q));
        {wx0_d, wx1_d, wy0_d, wy1_d} = {wx0_q, wx1_q, wy0_q, wy1_q};
        {lo_d, hi_d}                 = {lo_q, hi_q};
        {spix_d, sund_d, sovr_d}     = {spix_q, sund_q, sovr_q};
        sum_d = sum_q;
        pix_d = pix_q;
        und_d = und_q;
        ovr_d = ovr_q;
        if (vs_ps) begin
            // New frame: take config for it, hand the last frame to the divider.
            {wx0_d, wx1_d, wy0_d, wy1_d} = {win_x0, win_x1, win_y0, win_y1};
            {lo_d, hi_d}                 = {thr_lo, thr_hi};
            {spix_d, sund_d, sovr_d}     = {pix_q, und_q, ovr_q};
            sum_d = '0;
            pix_d = '0;
            und_d = '0;
            ovr_d = '0;
        end else if (in_win) begin
            sum_d = sum_ext[C_SUM_WIDTH] ? '1 : sum_ext[C_SUM_WIDTH-1:0];
            pix_d = pix_q + C_CNT_WIDTH'(sat_inc_en(&pix_q));
            if (data_in < lo_q) und_d = und_q + C_CNT_WIDTH'(sat_inc_en(&und_q));
            if (data_in > hi_q) ovr_d = ovr_q + C_CNT_WIDTH'(sat_inc_en(&ovr_q));
        end
    end

    // Datapath registers.
    always_ff @(posedge pix_clk) begin
        if (reset) begin
            vs_dly_q <= 1'b0;
            de_dly_q <= 1'b0;
            x_q      <= '0;
            y_q      <= '0;
            {wx0_q, wx1_q, wy0_q, wy1_q} <= '0;
            {lo_q, hi_q}                 <= '0;
            {spix_q, sund_q, sovr_q}     <= '0;
            sum_q    <= '0;
            pix_q    <= '0;
            und_q    <= '0;
            ovr_q    <= '0;
        end else begin
            vs_dly_q <= vs_dly_d;
            de_dly_q <= de_dly_d;
            x_q      <= x_d;
            y_q      <= y_d;
            {wx0_q, wx1_q, wy0_q, wy1_q} <= {wx0_d, wx1_d, wy0_d, wy1_d};
            {lo_q, hi_q}                 <= {lo_d, hi_d};
            {spix_q, sund_q, sovr_q}     <= {spix_d, sund_d, sovr_d};
            sum_q    <= sum_d;
            pix_q    <= pix_d;
            und_q    <= und_d;
            ovr_q    <= ovr_d;
        end
    end

    // A frame start while dividing simply restarts on the new snapshot.
    assign div_start = vs_ps & armed_q;
    assign div_abort = vs_ps & (state_q == ST_DIV);

    ae_div #(
        .C_SUM_WIDTH (C_SUM_WIDTH),
        .C_CNT_WIDTH (C_CNT_WIDTH)
    ) u_div (
        .clk      (pix_clk),
        .reset    (reset),
        .start    (div_start),
        .abort    (div_abort),
        .dividend (sum_q),
        .divisor  (pix_q),
        .quotient (div_quo),
        .done     (div_done)
    );

    // Quotient only overflows the pixel width when the sum saturated.
    assign mean_clamped = (|div_quo[C_SUM_WIDTH-1:C_DATA_WIDTH]) ? '1
                                                                 : div_quo[C_DATA_WIDTH-1:0];

    // Control FSM: arm on the first frame edge, then divide and publish.
    always_ff @(posedge pix_clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            armed_q      <= 1'b0;
            stat_valid_q <= 1'b0;
            mean_q       <= '0;
            pix_out_q    <= '0;
            und_out_q    <= '0;
            ovr_out_q    <= '0;
        end else begin
            stat_valid_q <= 1'b0;
            if (vs_ps) armed_q <= 1'b1;
            if (div_start) begin
                state_q <= ST_DIV;
            end else begin
                case (state_q)
                    ST_DIV: begin
                        if (div_done) begin
                            state_q      <= ST_DONE;
                            stat_valid_q <= 1'b1;
                            mean_q       <= mean_clamped;
                            pix_out_q    <= spix_q;
                            und_out_q    <= sund_q;
                            ovr_out_q    <= sovr_q;
                        end
                    end
                    ST_DONE: state_q <= ST_IDLE;
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign mean_out   = mean_q;
    assign pix_cnt    = pix_out_q;
    assign under_cnt  = und_out_q;
    assign over_cnt   = ovr_out_q;
    assign stat_valid = stat_valid_q;
    assign busy       = (state_q == ST_DIV);

endmodule

// File: tb/tb_ae_stat.sv
// Directed bench for ae_stat: frames of known content, checked for mean,
// counts, busy window and exact stat_valid timing.
module tb_ae_stat;
    logic        pix_clk = 1'b0;
    logic        reset, vs_in, hs_in, de_in;
    logic [7:0]  data_in, thr_lo, thr_hi;
    logic [11:0] win_x0, win_x1, win_y0, win_y1;
    logic [7:0]  mean_out;
    logic [23:0] pix_cnt, under_cnt, over_cnt;
    logic        stat_valid, busy;

    int total = 0;
    int bad   = 0;

    ae_stat dut (
        .pix_clk(pix_clk), .reset(reset), .vs_in(vs_in), .hs_in(hs_in),
        .de_in(de_in), .data_in(data_in),
        .win_x0(win_x0), .win_x1(win_x1), .win_y0(win_y0), .win_y1(win_y1),
        .thr_lo(thr_lo), .thr_hi(thr_hi),
        .mean_out(mean_out), .pix_cnt(pix_cnt), .under_cnt(under_cnt),
        .over_cnt(over_cnt), .stat_valid(stat_valid), .busy(busy)
    );

    always #5 pix_clk = ~pix_clk;

    task automatic tick;
        @(posedge pix_clk);
        #1;
    endtask

    task automatic set_cfg(input int x0, input int x1, input int y0, input int y1,
                           input int lo, input int hi);
        win_x0 = 12'(x0); win_x1 = 12'(x1); win_y0 = 12'(y0); win_y1 = 12'(y1);
        thr_lo = 8'(lo);  thr_hi = 8'(hi);
    endtask

    function automatic logic [7:0] pix_val(input int mode, input int x);
        case (mode)
            0:       return 8'd100;
            1:       return 8'(x * 16);
            default: return (x % 2 == 1) ? 8'd250 : 8'd10;
        endcase
    endfunction

    task automatic send_frame(input int w, input int h, input int mode);
        tick; tick;
        for (int y = 0; y < h; y++) begin
            for (int x = 0; x < w; x++) begin
                de_in = 1'b1; data_in = pix_val(mode, x);
                tick;
            end
            de_in = 1'b0; data_in = 8'd0;
            tick; tick;
        end
    endtask

    task automatic check_outs(input string name, input int m, input int p,
                              input int u, input int o);
        total++; if (mean_out !== 8'(m))   begin bad++; $display("FAIL %s mean got=%0d exp=%0d", name, mean_out, m); end
        total++; if (pix_cnt !== 24'(p))   begin bad++; $display("FAIL %s pix got=%0d exp=%0d", name, pix_cnt, p); end
        total++; if (under_cnt !== 24'(u)) begin bad++; $display("FAIL %s under got=%0d exp=%0d", name, under_cnt, u); end
        total++; if (over_cnt !== 24'(o))  begin bad++; $display("FAIL %s over got=%0d exp=%0d", name, over_cnt, o); end
    endtask

    // Raise vs (cycle T) and watch T+1..T+40; pulse expected only at T+33.
    task automatic frame_end(input string name, input bit pulse, input int m,
                             input int p, input int u, input int o);
        int vbad = 0, bbad = 0;
        vs_in = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            tick;
            if (i == 1) vs_in = 1'b0;
            if (busy !== (pulse && i <= 32)) bbad++;
            if (stat_valid !== (pulse && i == 33)) vbad++;
            if (pulse && i == 33) check_outs(name, m, p, u, o);
        end
        total++; if (bbad != 0) begin bad++; $display("FAIL %s busy_window wrong_cycles=%0d exp=0", name, bbad); end
        total++; if (vbad != 0) begin bad++; $display("FAIL %s valid_timing wrong_cycles=%0d exp=0", name, vbad); end
    endtask

    task automatic test_reset;
        reset = 1'b1; vs_in = 0; hs_in = 0; de_in = 0; data_in = 0;
        set_cfg(0, 0, 0, 0, 0, 0);
        tick; tick; tick;
        reset = 1'b0;
        check_outs("reset", 0, 0, 0, 0);
        total++; if (stat_valid !== 1'b0) begin bad++; $display("FAIL reset valid got=%0b exp=0", stat_valid); end
        total++; if (busy !== 1'b0)       begin bad++; $display("FAIL reset busy got=%0b exp=0", busy); end
    endtask

    task automatic test_const;
        set_cfg(0, 7, 0, 3, 20, 200);
        frame_end("arm", 0, 0, 0, 0, 0);
        send_frame(8, 4, 0);
        frame_end("const", 1, 100, 32, 0, 0);
    endtask

    task automatic test_ramp;
        set_cfg(4, 7, 1, 2, 20, 200);
        frame_end("ramp_sync", 1, 0, 0, 0, 0);
        send_frame(16, 4, 1);
        frame_end("ramp", 1, 88, 8, 0, 0);
    endtask

    task automatic test_thresh;
        set_cfg(0, 7, 0, 3, 20, 200);
        frame_end("thr_sync", 1, 0, 0, 0, 0);
        send_frame(8, 4, 2);
        frame_end("thr", 1, 130, 32, 16, 16);
        set_cfg(0, 7, 0, 3, 251, 9);
        frame_end("swap_sync", 1, 0, 0, 0, 0);
        send_frame(8, 4, 2);
        frame_end("thr_swap", 1, 130, 32, 32, 32);
    endtask

    task automatic test_empty;
        set_cfg(5, 2, 0, 3, 20, 200);
        frame_end("empty_sync", 1, 0, 0, 0, 0);
        send_frame(8, 4, 0);
        frame_end("empty", 1, 0, 0, 0, 0);
    endtask

    // Second frame edge at T+10: old division dropped, new one ends at T+43.
    task automatic test_abort;
        int vbad = 0, bbad = 0;
        set_cfg(0, 7, 0, 3, 20, 200);
        frame_end("abort_sync", 1, 0, 0, 0, 0);
        send_frame(8, 4, 0);
        vs_in = 1'b1;
        for (int i = 1; i <= 46; i++) begin
            tick;
            vs_in = (i == 10);
            de_in = (i >= 3 && i <= 6);
            data_in = de_in ? 8'd40 : 8'd0;
            if (busy !== (i <= 42)) bbad++;
            if (stat_valid !== (i == 43)) vbad++;
            if (i == 43) check_outs("abort", 40, 4, 0, 0);
        end
        total++; if (bbad != 0) begin bad++; $display("FAIL abort busy_window wrong_cycles=%0d exp=0", bbad); end
        total++; if (vbad != 0) begin bad++; $display("FAIL abort valid_timing wrong_cycles=%0d exp=0", vbad); end
    endtask

    task automatic test_reset_mid_and_cfg;
        int vcnt = 0;
        vs_in = 1'b1; tick;
        vs_in = 1'b0; tick; tick; tick;
        reset = 1'b1; tick;
        reset = 1'b0;
        check_outs("rst_mid", 0, 0, 0, 0);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_mid busy got=%0b exp=0", busy); end
        for (int i = 0; i < 36; i++) begin
            tick;
            if (stat_valid) vcnt++;
        end
        total++; if (vcnt != 0) begin bad++; $display("FAIL rst_mid stray_valid got=%0d exp=0", vcnt); end
        set_cfg(0, 7, 0, 3, 20, 200);
        frame_end("rst_arm", 0, 0, 0, 0, 0);
        send_frame(8, 2, 0);
        win_x1 = 12'd3;
        send_frame(8, 2, 0);
        frame_end("old_win", 1, 100, 32, 0, 0);
        send_frame(8, 4, 1);
        frame_end("new_win", 1, 24, 16, 8, 0);
    endtask

    initial begin
        test_reset;
        test_const;
        test_ramp;
        test_thresh;
        test_empty;
        test_abort;
        test_reset_mid_and_cfg;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout total=%0d", total);
        $fatal(1, "timeout");
    end

endmodule
